grid_arbiter: RTL and testbench
===============================

GRID_ARBITER -- requirements
Module: grid_arbiter

Interface
REQ-001 SHALL have parameters, one per line:
 - NREQ, 2, number of requesters
 - ADDR_W, 32, address width
 - DATA_W, 32, data width
 - GRID_CELLS, 49, valid cell count (n*n)
 - EMPTY, all-ones, empty-cell marker (-1)
REQ-002 SHALL have ports (name, direction, width, meaning):
 - clk, in, 1, single clock, rising edge
 - reset, in, 1, asynchronous active-high reset
 - req, in, NREQ, per-requester request, held until done
 - op, in, 2*NREQ, per-requester op: 00 read, 01 write, 10 claim, 11 no-op
 - addr, in, ADDR_W*NREQ, per-requester cell address
 - wdata, in, DATA_W*NREQ, per-requester write/claim data (node id)
 - gnt, out, NREQ, one-hot grant, held for the whole transaction
 - done, out, NREQ, one-cycle completion pulse to the winner
 - rdata, out, DATA_W, cell value read (read/claim)
 - claim_ok, out, 1, claim result, valid with done
 - busy, out, 1, transaction in flight
 - conflicts, out, 16, saturating count of failed claims
 - mem_re, out, 1, grid RAM read strobe
 - mem_we, out, 1, grid RAM write strobe
 - mem_addr, out, ADDR_W, grid RAM address
 - mem_wdata, out, DATA_W, grid RAM write data
 - mem_rdata, in, DATA_W, grid RAM read data; 1-cycle registered latency

Function
REQ-003 SHALL be a registered FSM with states IDLE, RD, RWAIT, WR, CW, DONE; every output is decoded from registered state only.
REQ-004 IDLE: if any req bit is set, the edge SHALL select a winner by round-robin, starting at pointer rr. It SHALL latch the winner's op, addr and wdata, set gnt and busy, and move to:
 - RD for read or claim
 - WR for write
 - DONE for no-op or for addr >= GRID_CELLS
REQ-005 RD SHALL assert mem_re with mem_addr set to the latched addr for one cycle, then move to RWAIT.
REQ-006 RWAIT SHALL capture mem_rdata into rdata, then move as follows:
 - read: to DONE
 - claim with mem_rdata == EMPTY: to CW, claim_ok=1
 - claim otherwise: to DONE, claim_ok=0, conflicts incremented and saturating at 16'hFFFF
REQ-007 WR and CW SHALL assert mem_we, mem_addr=addr and mem_wdata=wdata for one cycle, then move to DONE.
REQ-008 DONE SHALL pulse done[winner] for exactly one cycle, deassert gnt and busy, set rr=(winner+1) mod NREQ, and return to IDLE.
REQ-009 Latency from the sampling edge to done high SHALL be: read 3 edges, write 2, successful claim 4, failed claim 3, no-op or out-of-range 1.
REQ-010 Claim read-check-write SHALL be atomic: no other requester's memory access is interleaved.
REQ-011 Out-of-range addr SHALL produce no mem_re or mem_we, rdata=EMPTY and claim_ok=0; it SHALL NOT increment conflicts.
REQ-012 A req deasserted mid-transaction SHALL NOT abort it; the transaction completes and done pulses.
REQ-013 A requester re-asserting req in the DONE cycle SHALL lose to any other pending requester on the next arbitration.
REQ-014 mem_re and mem_we SHALL never be asserted in the same cycle; neither is asserted outside RD/WR/CW.
REQ-015 rdata and claim_ok SHALL hold their values until the next transaction's RWAIT or DONE updates them.

Reset
REQ-016 Asserting reset SHALL immediately force the following, independent of clk:
 - state IDLE, rr=0
 - gnt=0, done=0, busy=0
 - rdata=0, claim_ok=0, conflicts=0
 - mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0
REQ-017 Reset during any state SHALL abort the transaction, and no pending write is issued after reset releases.

Verification
REQ-018 Grid cell 10 preloaded EMPTY; req0 claim addr=10 wdata=3 -> gnt=01; mem_re, then mem_we at 10 with data 3; done[0] 4 edges after sampling; claim_ok=1.
REQ-019 Then req1 claim addr=10 wdata=5 -> claim_ok=0, rdata=3, conflicts=1, no mem_we.
REQ-020 req0 and req1 both read in the same cycle from reset -> req0 served first and req1 next, with gnt never both high.
REQ-021 req0 write addr=49 -> done after 1 edge; no mem_we; rdata=EMPTY; conflicts unchanged.
REQ-022 Reset asserted during CW -> all outputs 0 asynchronously; cell stays EMPTY after release.
REQ-023 Force conflicts=16'hFFFE, then two failed claims -> conflicts=16'hFFFF and stays there.

Source files
------------

// File: rtl/grid_arbiter.sv
// grid_arbiter: round-robin arbiter that gives NREQ requesters serialized
// access to a shared grid RAM. Supports read, write, atomic claim
// (read-check-write on an EMPTY cell) and no-op. Claim failures are counted.
//
// Handshake: a requester raises req with op/addr/wdata stable and holds it
// until it sees its done bit. gnt stays high from the arbitration edge
// through the DONE cycle. done pulses for exactly one cycle. rdata and
// claim_ok are valid with done and hold until a later transaction updates
// them. Dropping req mid-transaction does not abort it.
module grid_arbiter #(
    parameter int                NREQ       = 2,
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                GRID_CELLS = 49,
    parameter logic [DATA_W-1:0] EMPTY      = '1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [2*NREQ-1:0]        op,
    input  logic [ADDR_W*NREQ-1:0]   addr,
    input  logic [DATA_W*NREQ-1:0]   wdata,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          done,
    output logic [DATA_W-1:0]        rdata,
    output logic                     claim_ok,
    output logic                     busy,
    output logic [15:0]              conflicts,
    output logic                     mem_re,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic [2:0]               dbg_state
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] OP_RD  = 2'b00;
    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_CL  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_RWAIT = 3'd2,
        ST_WR    = 3'd3,
        ST_CW    = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    winner_q, winner_d;
    logic [IDX_W-1:0]    rr_q, rr_d;
    logic [1:0]          op_q, op_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                claim_ok_q, claim_ok_d;
    logic [15:0]         conflicts_q, conflicts_d;

    // Per-requester views of the flattened request buses.
    logic [1:0]          op_arr    [NREQ];
    logic [ADDR_W-1:0]   addr_arr  [NREQ];
    logic [DATA_W-1:0]   wdata_arr [NREQ];

    logic                arb_found;
    logic [IDX_W-1:0]    arb_pick;
    logic [IDX_W-1:0]    cand;
    int                  cand_i;
    logic [1:0]          sel_op;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_oor;

    // Split the flattened request buses into per-requester fields.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            op_arr[i]    = op[2*i +: 2];
            addr_arr[i]  = addr[ADDR_W*i +: ADDR_W];
            wdata_arr[i] = wdata[DATA_W*i +: DATA_W];
        end
    end

    // Round-robin search: first requester at or after rr_q, wrapping.
    always_comb begin
        arb_found = 1'b0;
        arb_pick  = '0;
        cand_i    = 0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_i = int'(rr_q) + k;
            if (cand_i >= NREQ) begin
                cand_i = cand_i - NREQ;
            end
            cand = IDX_W'(cand_i);
            if (!arb_found && req[cand]) begin
                arb_found = 1'b1;
                arb_pick  = cand;
            end
        end
    end

    // Fields of the arbitration candidate, plus its address range check.
    always_comb begin
        sel_op    = op_arr[arb_pick];
        sel_addr  = addr_arr[arb_pick];
        sel_wdata = wdata_arr[arb_pick];
        sel_oor   = (sel_addr >= ADDR_W'(GRID_CELLS));
    end

    // State and datapath registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            winner_q    <= '0;
            rr_q        <= '0;
            op_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            claim_ok_q  <= 1'b0;
            conflicts_q <= '0;
        end else begin
            state_q     <= state_d;
            winner_q    <= winner_d;
            rr_q        <= rr_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            claim_ok_q  <= claim_ok_d;
            conflicts_q <= conflicts_d;
        end
    end

    // Next-state and datapath update for each FSM state.
    always_comb begin
        state_d     = state_q;
        winner_d    = winner_q;
        rr_d        = rr_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        claim_ok_d  = claim_ok_q;
        conflicts_d = conflicts_q;
        unique case (state_q)
            ST_IDLE: begin
                if (arb_found) begin
                    winner_d = arb_pick;
                    op_d     = sel_op;
                    addr_d   = sel_addr;
                    wdata_d  = sel_wdata;
                    if (sel_oor) begin
                        // Out-of-range cells complete immediately, no RAM access.
                        rdata_d    = EMPTY;
                        claim_ok_d = 1'b0;
                        state_d    = ST_DONE;
                    end else if (sel_op == OP_RD || sel_op == OP_CL) begin
                        state_d = ST_RD;
                    end else if (sel_op == OP_WR) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RD: begin
                state_d = ST_RWAIT;
            end
            ST_RWAIT: begin
                rdata_d = mem_rdata;
                if (op_q == OP_CL) begin
                    if (mem_rdata == EMPTY) begin
                        // Cell free: write follows directly, nobody else can
                        // reach the RAM before it.
                        claim_ok_d = 1'b1;
                        state_d    = ST_CW;
                    end else begin
                        claim_ok_d = 1'b0;
                        if (conflicts_q != 16'hFFFF) begin
                            conflicts_d = conflicts_q + 16'd1;
                        end
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_WR, ST_CW: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                // Winner moves to the back of the round-robin order.
                rr_d    = (winner_q == IDX_W'(NREQ-1)) ? '0 : winner_q + IDX_W'(1);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state only.
    always_comb begin
        gnt       = '0;
        done      = '0;
        busy      = 1'b0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_q != ST_IDLE) begin
            gnt[winner_q] = 1'b1;
            busy          = 1'b1;
        end
        unique case (state_q)
            ST_RD: begin
                mem_re   = 1'b1;
                mem_addr = addr_q;
            end
            ST_WR, ST_CW: begin
                mem_we    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
            end
            ST_DONE: begin
                done[winner_q] = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign rdata     = rdata_q;
    assign claim_ok  = claim_ok_q;
    assign conflicts = conflicts_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_grid_arbiter.sv
// Testbench for grid_arbiter: grid RAM model, transaction-level reference
// model, directed scenarios followed by randomized transactions.
module tb_grid_arbiter;

    localparam int          GRID  = 49;
    localparam logic [31:0] EMPTY = 32'hFFFF_FFFF;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    logic [1:0]  req;
    logic [3:0]  op;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [1:0]  gnt, done;
    logic [31:0] rdata;
    logic        claim_ok, busy;
    logic [15:0] conflicts;
    logic        mem_re, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  dbg_state;

    grid_arbiter dut (
        .clk(clk), .reset(reset), .req(req), .op(op), .addr(addr), .wdata(wdata),
        .gnt(gnt), .done(done), .rdata(rdata), .claim_ok(claim_ok), .busy(busy),
        .conflicts(conflicts), .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
    );

    // ---------------- grid RAM (1-cycle registered read) ----------------
    logic [31:0] ram [0:63];
    int          re_cnt = 0, we_cnt = 0, overlap_cnt = 0, multi_gnt_cnt = 0;
    logic [31:0] last_we_addr = '0, last_we_data = '0;

    always @(posedge clk) begin
        if (mem_re) mem_rdata <= (mem_addr < 64) ? ram[mem_addr[5:0]] : 32'hDEAD_BEEF;
        if (mem_we && mem_addr < 64) ram[mem_addr[5:0]] <= mem_wdata;
        if (mem_re) re_cnt <= re_cnt + 1;
        if (mem_we) begin
            we_cnt       <= we_cnt + 1;
            last_we_addr <= mem_addr;
            last_we_data <= mem_wdata;
        end
        if (mem_re && mem_we) overlap_cnt <= overlap_cnt + 1;
        if (gnt == 2'b11) multi_gnt_cnt <= multi_gnt_cnt + 1;
    end

    // ---------------- reference model state ----------------
    logic [31:0] ref_grid [0:63];
    int          m_rr;
    logic [31:0] m_rdata;
    logic        m_ok;
    logic [15:0] m_conf;

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_rr    = 0;
        m_rdata = '0;
        m_ok    = 1'b0;
        m_conf  = '0;
    endtask

    // Wait for any done bit, bounded; reports the edge count and whether seen.
    task automatic wait_done(output int lat, output logic seen);
        lat  = 0;
        seen = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            #1;
            if (done != 2'b00) begin
                lat  = e;
                seen = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- driver: one transaction from one requester ----------------
    task automatic do_txn(input int who, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] d, input string tag);
        int          exp_lat, exp_re, exp_we, lat, re0, we0;
        logic        seen;
        logic [31:0] e_lat, e_rd, e_ok, e_conf;
        // reference model: outcome from the operation rules
        exp_re = 0;
        exp_we = 0;
        if (a >= GRID) begin
            exp_lat = 1;
            m_rdata = EMPTY;
            m_ok    = 1'b0;
        end else begin
            case (o)
                2'b00: begin exp_lat = 3; exp_re = 1; m_rdata = ref_grid[a]; end
                2'b01: begin exp_lat = 2; exp_we = 1; ref_grid[a] = d; end
                2'b10: begin
                    exp_re  = 1;
                    m_rdata = ref_grid[a];
                    if (ref_grid[a] == EMPTY) begin
                        exp_lat     = 4;
                        exp_we      = 1;
                        m_ok        = 1'b1;
                        ref_grid[a] = d;
                    end else begin
                        exp_lat = 3;
                        m_ok    = 1'b0;
                        if (m_conf != 16'hFFFF) m_conf = m_conf + 16'd1;
                    end
                end
                default: exp_lat = 1;
            endcase
        end
        m_rr = (who + 1) % 2;
        exp_q.push_back(32'(exp_lat));
        exp_q.push_back(m_rdata);
        exp_q.push_back({31'd0, m_ok});
        exp_q.push_back({16'd0, m_conf});

        @(negedge clk);
        re0 = re_cnt;
        we0 = we_cnt;
        req[who]              = 1'b1;
        op[2*who +: 2]        = o;
        addr[32*who +: 32]    = a;
        wdata[32*who +: 32]   = d;
        wait_done(lat, seen);
        req[who] = 1'b0;

        e_lat  = exp_q.pop_front();
        e_rd   = exp_q.pop_front();
        e_ok   = exp_q.pop_front();
        e_conf = exp_q.pop_front();
        check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
        check({tag, "_latency"},   32'(lat), e_lat);
        check({tag, "_done"},      {30'd0, done}, 32'd1 << who);
        check({tag, "_gnt"},       {30'd0, gnt},  32'd1 << who);
        check({tag, "_busy"},      {31'd0, busy}, 32'd1);
        check({tag, "_rdata"},     rdata, e_rd);
        check({tag, "_claim_ok"},  {31'd0, claim_ok}, e_ok);
        check({tag, "_conflicts"}, {16'd0, conflicts}, e_conf);
        check({tag, "_re_count"},  32'(re_cnt - re0), 32'(exp_re));
        check({tag, "_we_count"},  32'(we_cnt - we0), 32'(exp_we));
        if (a < GRID) check({tag, "_cell"}, ram[a[5:0]], ref_grid[a]);

        @(posedge clk);
        #1;
        check({tag, "_idle_gnt"},  {30'd0, gnt},  32'd0);
        check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_idle_done"}, {30'd0, done}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          lat, expw;
        logic        seen;
        logic [1:0]  o;
        logic [31:0] a;

        for (int i = 0; i < 64; i++) begin
            ram[i]      = EMPTY;
            ref_grid[i] = EMPTY;
        end
        mem_rdata = '0;
        req   = '0;
        op    = '0;
        addr  = '0;
        wdata = '0;
        reset = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;

        // reset state
        check("rst_gnt",       {30'd0, gnt},       32'd0);
        check("rst_done",      {30'd0, done},      32'd0);
        check("rst_busy",      {31'd0, busy},      32'd0);
        check("rst_rdata",     rdata,              32'd0);
        check("rst_claim_ok",  {31'd0, claim_ok},  32'd0);
        check("rst_conflicts", {16'd0, conflicts}, 32'd0);
        check("rst_mem_re",    {31'd0, mem_re},    32'd0);
        check("rst_mem_we",    {31'd0, mem_we},    32'd0);
        check("rst_mem_addr",  mem_addr,           32'd0);
        check("rst_mem_wdata", mem_wdata,          32'd0);
        @(negedge clk);
        reset = 1'b0;

        // both requesters read at once from reset; both held, so the
        // winner of each round re-requests in DONE and must yield
        ram[5] = 32'h0000_0505; ref_grid[5] = 32'h0000_0505;
        ram[6] = 32'h0000_0606; ref_grid[6] = 32'h0000_0606;
        @(negedge clk);
        req   = 2'b11;
        op    = 4'b0000;
        addr  = {32'd6, 32'd5};
        for (int t = 0; t < 3; t++) begin
            expw = m_rr;
            wait_done(lat, seen);
            check("rr_done_seen", {31'd0, seen}, 32'd1);
            check("rr_latency",   32'(lat), (t == 0) ? 32'd3 : 32'd4);
            check("rr_done",      {30'd0, done}, 32'd1 << expw);
            check("rr_gnt",       {30'd0, gnt},  32'd1 << expw);
            check("rr_rdata",     rdata, ref_grid[5 + expw]);
            m_rr = (expw + 1) % 2;
        end
        req = 2'b00;
        m_rdata = rdata;
        @(posedge clk);
        #1;
        check("rr_multi_gnt", 32'(multi_gnt_cnt), 32'd0);

        // claim of an EMPTY cell, then a conflicting claim of the same cell
        do_txn(0, 2'b10, 32'd10, 32'd3, "claim_ok");
        check("claim_we_addr", last_we_addr, 32'd10);
        check("claim_we_data", last_we_data, 32'd3);
        do_txn(1, 2'b10, 32'd10, 32'd5, "claim_fail");

        // out-of-range write
        do_txn(0, 2'b01, 32'd49, 32'h1234, "oor_write");

        // randomized traffic (cell 48 reserved for the reset test)
        for (int n = 0; n < 40; n++) begin
            o = 2'($urandom_range(0, 3));
            a = ($urandom_range(0, 5) == 0) ? 32'($urandom_range(49, 60))
                                            : 32'($urandom_range(0, 15));
            do_txn($urandom_range(0, 1), o, a, $urandom, "rand");
        end

        // conflict counter saturation
        @(negedge clk);
        force dut.conflicts_q = 16'hFFFE;
        @(posedge clk);
        @(negedge clk);
        release dut.conflicts_q;
        m_conf = 16'hFFFE;
        #1;
        check("sat_preload", {16'd0, conflicts}, 32'h0000_FFFE);
        do_txn(1, 2'b01, 32'd11, 32'h55, "sat_fill");
        do_txn(0, 2'b10, 32'd11, 32'h66, "sat_1");
        do_txn(1, 2'b10, 32'd11, 32'h77, "sat_2");

        // reset in the middle of a claim write
        @(negedge clk);
        req[0]         = 1'b1;
        op[1:0]        = 2'b10;
        addr[31:0]     = 32'd48;
        wdata[31:0]    = 32'd7;
        repeat (3) @(posedge clk);
        #1;
        check("cw_mem_we",    {31'd0, mem_we}, 32'd1);
        check("cw_mem_addr",  mem_addr,  32'd48);
        check("cw_mem_wdata", mem_wdata, 32'd7);
        #1;
        reset = 1'b1;
        #1;
        check("cw_rst_gnt",       {30'd0, gnt},       32'd0);
        check("cw_rst_busy",      {31'd0, busy},      32'd0);
        check("cw_rst_done",      {30'd0, done},      32'd0);
        check("cw_rst_mem_we",    {31'd0, mem_we},    32'd0);
        check("cw_rst_mem_addr",  mem_addr,           32'd0);
        check("cw_rst_mem_wdata", mem_wdata,          32'd0);
        check("cw_rst_rdata",     rdata,              32'd0);
        check("cw_rst_claim_ok",  {31'd0, claim_ok},  32'd0);
        check("cw_rst_conflicts", {16'd0, conflicts}, 32'd0);
        req = 2'b00;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("cw_cell_empty", ram[48], EMPTY);
        do_txn(1, 2'b00, 32'd48, 32'd0, "post_rst_read");

        check("re_we_overlap", 32'(overlap_cnt), 32'd0);
        check("multi_gnt",     32'(multi_gnt_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
